// File: rtl/ld3320_bus_master_pkg.sv
// ld3320_bus_master_pkg
// Shared definitions for the LD3320 parallel-bus master: FSM state encoding,
// idle levels of the chip pins and the mapping from a bus phase to the value
// loaded into the phase timer (phase length in cycles minus one).
package ld3320_bus_master_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE        = 4'd0;
    localparam state_t ST_WAIT_WD     = 4'd1;
    localparam state_t ST_ADDR_SETUP  = 4'd2;
    localparam state_t ST_ADDR_STROBE = 4'd3;
    localparam state_t ST_ADDR_HOLD   = 4'd4;
    localparam state_t ST_DATA_SETUP  = 4'd5;
    localparam state_t ST_DATA_STROBE = 4'd6;
    localparam state_t ST_DATA_HOLD   = 4'd7;
    localparam state_t ST_TURN        = 4'd8;

    // Levels the chip pins rest at whenever no access is in progress.
    localparam logic A0_IDLE  = 1'b0;
    localparam logic CSB_IDLE = 1'b1;
    localparam logic WRB_IDLE = 1'b1;
    localparam logic RDB_IDLE = 1'b1;

    // Timer reload value for a phase; untimed states (IDLE, WAIT_WD) map to 0.
    function automatic int phase_len(input state_t st,
                                     input int     t_setup,
                                     input int     t_strobe,
                                     input int     t_hold,
                                     input int     t_turn);
        int len;
        case (st)
            ST_ADDR_SETUP,  ST_DATA_SETUP:  len = t_setup - 1;
            ST_ADDR_STROBE, ST_DATA_STROBE: len = t_strobe - 1;
            ST_ADDR_HOLD,   ST_DATA_HOLD:   len = t_hold - 1;
            ST_TURN:                        len = t_turn - 1;
            default:                        len = 0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/ld3320_bus_master_if.sv
// ld3320_bus_master_if
// Groups the sequencer-side streams (command, write data, read data, status)
// and the LD3320 control pins (A0, CSB, WRB, RDB).
//   master modport : the bus master (drives ready/status/read data/pins)
//   slave modport  : the sequencer + chip side (drives command and write data)
// The bidirectional data bus P stays a plain inout port of the master.
interface ld3320_bus_master_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              cmd_inc;
    logic              wd_valid;
    logic              wd_ready;
    logic [DATA_W-1:0] wd_data;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              done;
    logic              busy;
    logic              A0;
    logic              CSB;
    logic              WRB;
    logic              RDB;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_inc, wd_valid, wd_data,
        output cmd_ready, wd_ready, rd_valid, rd_data, rd_last, done, busy,
               A0, CSB, WRB, RDB
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_inc, wd_valid, wd_data,
        input  cmd_ready, wd_ready, rd_valid, rd_data, rd_last, done, busy,
               A0, CSB, WRB, RDB
    );
endinterface

// File: rtl/ld3320_bus_master_phase_timer.sv
// ld3320_bus_master_phase_timer
// Loadable down-counter shared by all timed bus phases.
//   clk, rst    : clock, synchronous active-high reset
//   load_i      : load load_val_i this cycle (phase entry)
//   load_val_i  : phase length minus one
//   zero_o      : counter at zero, i.e. last cycle of the current phase
module ld3320_bus_master_phase_timer #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);
    logic [CNT_W-1:0] cnt_q;

    // Counter parks at zero once the phase has expired.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/ld3320_bus_master.sv
// ld3320_bus_master
// Executes register read/write bursts on the LD3320 parallel bus. Each beat
// is an address phase (A0=1, WRB strobe) followed by a data phase (A0=0, WRB
// or RDB strobe), each split into setup/strobe/hold, then a turnaround.
//   clk, rst : clock, synchronous active-high reset
//   bus      : command / write-data / read-data streams, status, chip pins
//   P        : chip data/address bus, released (hi-Z) unless this block drives
module ld3320_bus_master
    import ld3320_bus_master_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int LEN_W    = 4,
    parameter int T_SETUP  = 1,
    parameter int T_STROBE = 1,
    parameter int T_HOLD   = 1,
    parameter int T_TURN   = 1
) (
    input  logic                clk,
    input  logic                rst,
    ld3320_bus_master_if.master bus,
    inout  wire  [DATA_W-1:0]   P
);
    localparam int T_MAX_A = (T_SETUP > T_STROBE) ? T_SETUP : T_STROBE;
    localparam int T_MAX_B = (T_HOLD > T_TURN) ? T_HOLD : T_TURN;
    localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int CNT_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic              write_q, write_d;
    logic              inc_q, inc_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic              entry_q, entry_d;
    logic              phase_zero;
    logic              rd_pulse;
    logic              a0, csb, wrb, rdb;
    logic              p_oe;
    logic [DATA_W-1:0] p_out;

    ld3320_bus_master_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (entry_d),
        .load_val_i (CNT_W'(phase_len(state_d, T_SETUP, T_STROBE, T_HOLD, T_TURN))),
        .zero_o     (phase_zero)
    );

    // Sequencing of one command: accept, per-beat phases, burst stepping.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        beat_d  = beat_q;
        write_d = write_q;
        inc_d   = inc_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid && ready_q) begin
                    addr_d  = bus.cmd_addr;
                    len_d   = bus.cmd_len;
                    write_d = bus.cmd_write;
                    inc_d   = bus.cmd_inc;
                    beat_d  = '0;
                    state_d = bus.cmd_write ? ST_WAIT_WD : ST_ADDR_SETUP;
                end
            end
            ST_WAIT_WD: begin
                if (bus.wd_valid) begin
                    wdata_d = bus.wd_data;
                    state_d = ST_ADDR_SETUP;
                end
            end
            ST_ADDR_SETUP:  if (phase_zero) state_d = ST_ADDR_STROBE;
            ST_ADDR_STROBE: if (phase_zero) state_d = ST_ADDR_HOLD;
            ST_ADDR_HOLD:   if (phase_zero) state_d = ST_DATA_SETUP;
            ST_DATA_SETUP:  if (phase_zero) state_d = ST_DATA_STROBE;
            ST_DATA_STROBE: begin
                if (phase_zero) begin
                    // Read data is captured on the final strobe cycle.
                    if (!write_q) rdata_d = P;
                    state_d = ST_DATA_HOLD;
                end
            end
            ST_DATA_HOLD:   if (phase_zero) state_d = ST_TURN;
            ST_TURN: begin
                if (phase_zero) begin
                    if (beat_q == len_q) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        beat_d  = beat_q + LEN_W'(1);
                        addr_d  = addr_q + ADDR_W'(inc_q);
                        state_d = write_q ? ST_WAIT_WD : ST_ADDR_SETUP;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // cmd_ready is registered so it stays low through reset and rises only
    // once the engine has been out of reset for a cycle.
    assign ready_d = (state_d == ST_IDLE);
    assign entry_d = (state_d != state_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            write_q <= 1'b0;
            inc_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            entry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            write_q <= write_d;
            inc_q   <= inc_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            entry_q <= entry_d;
        end
    end

    // Pin levels decoded from the phase; P is driven only for addresses and
    // write data, so it is always released while RDB is low.
    always_comb begin
        a0    = A0_IDLE;
        csb   = CSB_IDLE;
        wrb   = WRB_IDLE;
        rdb   = RDB_IDLE;
        p_oe  = 1'b0;
        p_out = wdata_q;
        case (state_q)
            ST_ADDR_SETUP, ST_ADDR_HOLD: begin
                a0    = 1'b1;
                p_oe  = 1'b1;
                p_out = DATA_W'(addr_q);
            end
            ST_ADDR_STROBE: begin
                a0    = 1'b1;
                csb   = 1'b0;
                wrb   = 1'b0;
                p_oe  = 1'b1;
                p_out = DATA_W'(addr_q);
            end
            ST_DATA_SETUP, ST_DATA_HOLD: begin
                p_oe = write_q;
            end
            ST_DATA_STROBE: begin
                csb  = 1'b0;
                wrb  = !write_q;
                rdb  = write_q;
                p_oe = write_q;
            end
            default: ;
        endcase
    end

    assign P = p_oe ? p_out : {DATA_W{1'bz}};

    // rd_valid marks the first cycle of a read beat's data hold.
    assign rd_pulse = (state_q == ST_DATA_HOLD) && entry_q && !write_q;

    assign bus.A0        = a0;
    assign bus.CSB       = csb;
    assign bus.WRB       = wrb;
    assign bus.RDB       = rdb;
    assign bus.cmd_ready = ready_q;
    assign bus.wd_ready  = (state_q == ST_WAIT_WD);
    assign bus.rd_valid  = rd_pulse;
    assign bus.rd_last   = rd_pulse && (beat_q == len_q);
    assign bus.rd_data   = rdata_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_ld3320_bus_master.sv
// tb_ld3320_bus_master
// Scoreboard bench: dutA runs with all phase timings at 1, dutB with
// T_SETUP=2, T_STROBE=3, T_HOLD=1, T_TURN=2. Expected strobes and read
// results are queued as stimulus is issued and popped by the monitors.
module tb_ld3320_bus_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstA = 1'b1;
    logic rstB = 1'b1;
    wire [7:0] pA;
    wire [7:0] pB;

    ld3320_bus_master_if #(.DATA_W(8), .ADDR_W(8), .LEN_W(4)) busA ();
    ld3320_bus_master_if #(.DATA_W(8), .ADDR_W(8), .LEN_W(4)) busB ();

    ld3320_bus_master #(.T_SETUP(1), .T_STROBE(1), .T_HOLD(1), .T_TURN(1)) dutA (
        .clk (clk), .rst (rstA), .bus (busA), .P (pA)
    );

    ld3320_bus_master #(.T_SETUP(2), .T_STROBE(3), .T_HOLD(1), .T_TURN(2)) dutB (
        .clk (clk), .rst (rstB), .bus (busB), .P (pB)
    );

    typedef struct packed { logic a0; logic [7:0] val; } evt_t;
    typedef struct packed { logic [7:0] data; logic last; } rd_t;
    typedef struct packed { logic [7:0] data; logic [7:0] delay; } wd_t;

    evt_t evtQ[$];
    rd_t  rdQ[$];
    wd_t  wdQ[$];

    int vectorCount = 0;
    int missCount   = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Chip models: dutA's chip returns address^0x5A, dutB's returns 0x3C.
    logic [7:0] modelAddr = 8'h00;
    assign pA = (busA.RDB == 1'b0) ? (modelAddr ^ 8'h5A) : 8'hzz;
    assign pB = (busB.RDB == 1'b0) ? 8'h3C : 8'hzz;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed 0x%0h, required 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic pushEvt(input logic a0, input logic [7:0] val);
        evt_t e;
        e.a0 = a0; e.val = val;
        evtQ.push_back(e);
    endtask

    task automatic pushRd(input logic [7:0] data, input logic last);
        rd_t r;
        r.data = data; r.last = last;
        rdQ.push_back(r);
    endtask

    task automatic pushWd(input logic [7:0] data, input logic [7:0] delay);
        wd_t w;
        w.data = data; w.delay = delay;
        wdQ.push_back(w);
    endtask

    // dutA monitor: strobes, read results, completion.
    int doneCountA = 0, doneCycA = -1, rdCycA = -1, rdValidCountA = 0;
    int addrStrobeCycA = -1, dataStrobeCycA = -1, rdbLowCountA = 0;
    always @(negedge clk) begin : monA
        evt_t e;
        rd_t  r;
        if (busA.CSB == 1'b0 && busA.WRB == 1'b0) begin
            checkOutput("wrb_rdb_excl", busA.RDB, 1'b1);
            checkOutput("strobe_expected", evtQ.size() != 0, 1'b1);
            if (evtQ.size() != 0) begin
                e = evtQ.pop_front();
                checkOutput("strobe_a0", busA.A0, e.a0);
                checkOutput("strobe_p", pA, e.val);
            end
            if (busA.A0) begin
                modelAddr = pA;
                addrStrobeCycA = cyc;
            end else begin
                dataStrobeCycA = cyc;
            end
        end
        if (busA.RDB == 1'b0) begin
            rdbLowCountA++;
            checkOutput("rdb_a0", busA.A0, 1'b0);
            checkOutput("rdb_wrb_excl", busA.WRB, 1'b1);
        end
        if (busA.rd_valid) begin
            rdCycA = cyc;
            rdValidCountA++;
            checkOutput("rd_expected", rdQ.size() != 0, 1'b1);
            if (rdQ.size() != 0) begin
                r = rdQ.pop_front();
                checkOutput("rd_data", busA.rd_data, r.data);
                checkOutput("rd_last", busA.rd_last, r.last);
            end
        end
        if (busA.done) begin
            doneCountA++;
            doneCycA = cyc;
        end
    end

    // dutB monitor.
    int doneCountB = 0, doneCycB = -1, rdCycB = -1, rdbLowB = 0, wrbLowB = 0;
    logic [7:0] rdDataB = 8'h00;
    logic rdLastB = 1'b0;
    always @(negedge clk) begin
        if (busB.RDB == 1'b0) rdbLowB++;
        if (busB.WRB == 1'b0) wrbLowB++;
        if (busB.rd_valid) begin
            rdCycB  = cyc;
            rdDataB = busB.rd_data;
            rdLastB = busB.rd_last;
        end
        if (busB.done) begin
            doneCountB++;
            doneCycB = cyc;
        end
    end

    // Write-data source for dutA; a queued delay withholds wd_valid for that
    // many cycles of wd_ready.
    logic wdFire = 1'b0;
    int stallCycles = 0;
    always @(posedge clk) wdFire <= busA.wd_valid && busA.wd_ready;
    initial begin
        wd_t w;
        busA.wd_valid = 1'b0;
        busA.wd_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (wdFire && wdQ.size() != 0) void'(wdQ.pop_front());
            if (wdQ.size() == 0) begin
                busA.wd_valid = 1'b0;
            end else if (wdQ[0].delay != 0) begin
                busA.wd_valid = 1'b0;
                if (busA.wd_ready) begin
                    stallCycles++;
                    checkOutput("stall_csb_idle", busA.CSB, 1'b1);
                    checkOutput("stall_a0_idle", busA.A0, 1'b0);
                    w = wdQ[0];
                    w.delay = w.delay - 8'd1;
                    wdQ[0] = w;
                end
            end else begin
                busA.wd_valid = 1'b1;
                busA.wd_data  = wdQ[0].data;
            end
        end
    end

    int acceptCycA = -1;

    task automatic applyStimulus(input logic wr, input logic [7:0] addr,
                                 input logic [3:0] len, input logic inc,
                                 input bit keep);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        busA.cmd_valid = 1'b1;
        busA.cmd_write = wr;
        busA.cmd_addr  = addr;
        busA.cmd_len   = len;
        busA.cmd_inc   = inc;
        @(negedge clk);
        while (!busA.cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("cmd_accept", busA.cmd_ready, 1'b1);
        acceptCycA = cyc;
        @(posedge clk);
        #1;
        if (!keep) busA.cmd_valid = 1'b0;
    endtask

    task automatic waitDone(input int target, input int budget);
        int n;
        n = 0;
        while (doneCountA < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checkOutput("done_count", doneCountA, target);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int a1, a2, rdbBefore, rdvBefore, n, acceptB;
        busA.cmd_valid = 1'b0; busA.cmd_write = 1'b0; busA.cmd_addr = 8'h00;
        busA.cmd_len = 4'h0;   busA.cmd_inc = 1'b0;
        busB.cmd_valid = 1'b0; busB.cmd_write = 1'b0; busB.cmd_addr = 8'h00;
        busB.cmd_len = 4'h0;   busB.cmd_inc = 1'b0;
        busB.wd_valid = 1'b0;  busB.wd_data = 8'h00;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_csb", busA.CSB, 1'b1);
        checkOutput("rst_wrb", busA.WRB, 1'b1);
        checkOutput("rst_rdb", busA.RDB, 1'b1);
        checkOutput("rst_a0", busA.A0, 1'b0);
        checkOutput("rst_cmd_ready", busA.cmd_ready, 1'b0);
        checkOutput("rst_wd_ready", busA.wd_ready, 1'b0);
        checkOutput("rst_busy", busA.busy, 1'b0);
        checkOutput("rst_done", busA.done, 1'b0);
        checkOutput("rst_rd_valid", busA.rd_valid, 1'b0);
        checkOutput("rst_rd_data", busA.rd_data, 8'h00);
        rstA = 1'b0;
        rstB = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_rst", busA.cmd_ready, 1'b1);

        // Single write, data already offered.
        rdbBefore = rdbLowCountA;
        pushWd(8'hA5, 8'd0);
        pushEvt(1'b1, 8'h17);
        pushEvt(1'b0, 8'hA5);
        applyStimulus(1'b1, 8'h17, 4'h0, 1'b0, 1'b0);
        waitDone(1, 50);
        checkOutput("wr_addr_strobe_cyc", addrStrobeCycA - acceptCycA, 3);
        checkOutput("wr_data_strobe_cyc", dataStrobeCycA - acceptCycA, 6);
        checkOutput("wr_done_cyc", doneCycA - acceptCycA, 9);
        checkOutput("wr_rdb_quiet", rdbLowCountA - rdbBefore, 0);

        // Single read.
        pushEvt(1'b1, 8'h42);
        pushRd(8'h42 ^ 8'h5A, 1'b1);
        applyStimulus(1'b0, 8'h42, 4'h0, 1'b0, 1'b0);
        waitDone(2, 50);
        checkOutput("rd_valid_cyc", rdCycA - acceptCycA, 6);
        checkOutput("rd_done_cyc", doneCycA - acceptCycA, 8);

        // Read burst with address wrap.
        rdvBefore = rdValidCountA;
        pushEvt(1'b1, 8'hFE); pushRd(8'hFE ^ 8'h5A, 1'b0);
        pushEvt(1'b1, 8'hFF); pushRd(8'hFF ^ 8'h5A, 1'b0);
        pushEvt(1'b1, 8'h00); pushRd(8'h00 ^ 8'h5A, 1'b0);
        pushEvt(1'b1, 8'h01); pushRd(8'h01 ^ 8'h5A, 1'b1);
        applyStimulus(1'b0, 8'hFE, 4'h3, 1'b1, 1'b0);
        waitDone(3, 100);
        checkOutput("burst_rd_pulses", rdValidCountA - rdvBefore, 4);

        // Write burst, fixed address, data withheld before beat 1.
        stallCycles = 0;
        pushWd(8'h11, 8'd0);
        pushWd(8'h22, 8'd5);
        pushWd(8'h33, 8'd0);
        pushEvt(1'b1, 8'h60); pushEvt(1'b0, 8'h11);
        pushEvt(1'b1, 8'h60); pushEvt(1'b0, 8'h22);
        pushEvt(1'b1, 8'h60); pushEvt(1'b0, 8'h33);
        applyStimulus(1'b1, 8'h60, 4'h2, 1'b0, 1'b0);
        waitDone(4, 100);
        checkOutput("stall_cycles", stallCycles, 5);
        checkOutput("wr_burst_done_cyc", doneCycA - acceptCycA, 30);

        // Reset during the data strobe of a write burst.
        pushWd(8'h99, 8'd0);
        pushWd(8'hAA, 8'd0);
        pushEvt(1'b1, 8'h40); pushEvt(1'b0, 8'h99);
        applyStimulus(1'b1, 8'h40, 4'h1, 1'b1, 1'b0);
        n = 0;
        while (!(busA.WRB == 1'b0 && busA.A0 == 1'b0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reach_data_strobe", (busA.WRB == 1'b0 && busA.A0 == 1'b0), 1'b1);
        rstA = 1'b1;
        @(negedge clk);
        checkOutput("midrst_csb", busA.CSB, 1'b1);
        checkOutput("midrst_wrb", busA.WRB, 1'b1);
        checkOutput("midrst_busy", busA.busy, 1'b0);
        checkOutput("midrst_done", busA.done, 1'b0);
        rstA = 1'b0;
        @(posedge clk);
        #2;
        wdQ.delete();
        busA.wd_valid = 1'b0;
        @(negedge clk);
        checkOutput("midrst_ready", busA.cmd_ready, 1'b1);
        repeat (10) @(negedge clk);
        checkOutput("midrst_no_done", doneCountA, 4);
        pushWd(8'h55, 8'd0);
        pushEvt(1'b1, 8'h20); pushEvt(1'b0, 8'h55);
        applyStimulus(1'b1, 8'h20, 4'h0, 1'b0, 1'b0);
        waitDone(5, 50);
        checkOutput("post_rst_done_cyc", doneCycA - acceptCycA, 9);

        // Back-to-back: cmd_valid stays high into a second command.
        pushWd(8'h77, 8'd0);
        pushEvt(1'b1, 8'h30); pushEvt(1'b0, 8'h77);
        pushEvt(1'b1, 8'h31); pushRd(8'h31 ^ 8'h5A, 1'b1);
        applyStimulus(1'b1, 8'h30, 4'h0, 1'b0, 1'b1);
        a1 = acceptCycA;
        applyStimulus(1'b0, 8'h31, 4'h0, 1'b0, 1'b0);
        a2 = acceptCycA;
        waitDone(7, 50);
        checkOutput("b2b_accept_in_done", a2 - a1, 9);
        checkOutput("b2b_addr_strobe_cyc", addrStrobeCycA - a2, 2);
        checkOutput("b2b_done_cyc", doneCycA - a2, 8);

        // dutB: single read with stretched timing.
        @(posedge clk);
        #1;
        busB.cmd_valid = 1'b1;
        busB.cmd_write = 1'b0;
        busB.cmd_addr  = 8'h81;
        busB.cmd_len   = 4'h0;
        busB.cmd_inc   = 1'b0;
        n = 0;
        @(negedge clk);
        while (!busB.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("b_cmd_accept", busB.cmd_ready, 1'b1);
        acceptB = cyc;
        @(posedge clk);
        #1;
        busB.cmd_valid = 1'b0;
        n = 0;
        while (doneCountB < 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        checkOutput("b_done_count", doneCountB, 1);
        checkOutput("b_rdb_low_cycles", rdbLowB, 3);
        checkOutput("b_wrb_low_cycles", wrbLowB, 3);
        checkOutput("b_rd_data", rdDataB, 8'h3C);
        checkOutput("b_rd_last", rdLastB, 1'b1);
        checkOutput("b_rd_valid_cyc", rdCycB - acceptB, 12);
        checkOutput("b_done_cyc", doneCycB - acceptB, 15);

        checkOutput("evt_queue_drained", evtQ.size(), 0);
        checkOutput("rd_queue_drained", rdQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/ld3320_bus_master.md
Name: ld3320_bus_master

Overview:
- Parametrised successor to the single-access LD3320 register read/write engine.
- Executes queued register commands on the chip's parallel bus (P, A0, CSB, WRB, RDB) with programmable setup/strobe/hold/turnaround timing.
- Supports multi-beat bursts with optional address auto-increment.
- Sits between the voice-control sequencer (command/write-data/read-data streams) and the LD3320 pins.

Parameters:
- DATA_W, 8: bus and register data width.
- ADDR_W, 8: register address width.
- LEN_W, 4: burst length field width; a command carries up to 2^LEN_W beats.
- T_SETUP, 1: cycles that A0/P are stable before the strobe (>=1).
- T_STROBE, 1: cycles CSB plus WRB/RDB are held low (>=1).
- T_HOLD, 1: cycles A0/P are held after the strobe (>=1).
- T_TURN, 1: idle recovery cycles after each beat, CSB high, P released (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  accepting a command (IDLE only)
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_W  first register address
- cmd_len  in  LEN_W  beats minus one
- cmd_inc  in  1  1 = address +1 per beat, 0 = fixed address
- wd_valid  in  1  write beat data offered
- wd_ready  out  1  write beat data accepted
- wd_data  in  DATA_W  write beat data
- rd_valid  out  1  one-cycle pulse per read beat; no backpressure
- rd_data  out  DATA_W  sampled read data, held until the next read beat
- rd_last  out  1  qualifies rd_valid on the final beat
- done  out  1  one-cycle pulse at command completion
- busy  out  1  high from command accept until done
- P  inout  DATA_W  LD3320 data/address bus, hi-Z when not driven
- A0  out  1  1 = address phase, 0 = data phase
- CSB  out  1  chip select, active low
- WRB  out  1  write strobe, active low
- RDB  out  1  read strobe, active low

Behaviour:
- Reset: registered and synchronous. Sets state IDLE, A0=0, CSB=WRB=RDB=1, P hi-Z, cmd_ready=0, wd_ready=0, rd_valid=rd_last=done=busy=0, rd_data=0. cmd_ready rises the first cycle after rst deasserts.
- Reset mid-burst: the bus is idle and P is released the cycle after rst is sampled. No done or rd_valid pulse is produced. The remaining beats are discarded.
- Command accept: cmd_valid && cmd_ready in IDLE latches addr, len, write, inc, sets beat=0 and busy=1. Next state is WAIT_WD for a write, ADDR_SETUP for a read.
- WAIT_WD: wd_ready=1. On wd_valid, latch wd_data and go to ADDR_SETUP. Stalls indefinitely without wd_valid. wd_ready is 0 in all other states.
- ADDR_SETUP (T_SETUP): A0=1, P drives addr, CSB=WRB=1.
- ADDR_STROBE (T_STROBE): A0=1, P=addr, CSB=0, WRB=0.
- ADDR_HOLD (T_HOLD): A0=1, P=addr, CSB=WRB=1.
- DATA_SETUP (T_SETUP): A0=0. P drives the latched data on a write; hi-Z on a read.
- DATA_STROBE (T_STROBE): CSB=0, plus WRB=0 on a write or RDB=0 on a read. A read samples P on the last strobe cycle into rd_data.
- DATA_HOLD (T_HOLD): strobes high; write data still driven. rd_valid pulses in the first DATA_HOLD cycle of a read beat; rd_last=1 if beat==len.
- TURN (T_TURN): CSB=WRB=RDB=1, A0=0, P hi-Z.
  - If beat==len: go to IDLE with done=1 and busy=0 in that IDLE cycle; cmd_ready is also 1.
  - Otherwise: beat+1; addr+cmd_inc, wrapping modulo 2^ADDR_W; go to WAIT_WD (write) or ADDR_SETUP (read).
- Phase length: a shared down-counter is loaded with T_x-1 on phase entry and advances the phase at 0.
- Beat length: 2*(T_SETUP+T_STROBE+T_HOLD)+T_TURN cycles, plus 1 cycle for WAIT_WD on writes.
- Latency, all T=1: read accepted in cycle 0 pulses rd_valid in cycle 6 and done in cycle 8. A write with wd_valid already high gives done in cycle 9.
- Bus rule: P is driven only during address phases and write data phases, and is never driven while RDB=0.
- WRB and RDB are never low simultaneously.
- Commands offered while busy are held off (cmd_ready=0). len=all-ones gives 2^LEN_W beats.

Decomposition:
- ld3320_pkg: state enum (IDLE, WAIT_WD, ADDR_SETUP, ADDR_STROBE, ADDR_HOLD, DATA_SETUP, DATA_STROBE, DATA_HOLD, TURN), pin idle-level constants, and a phase-length function mapping state to T_x-1.
- Sub-module ld3320_phase_timer: loadable down-counter with a zero flag, width derived from the maximum T_x.

Test Plan:
- Single write, all T=1: cmd addr=0x17, len=0, wd_data=0xA5 pre-valid.
  -> A0=1 with P=0x17 while WRB low (cycle 3), then A0=0 with P=0xA5 while WRB low (cycle 6), done in cycle 9, RDB stays 1.
- Single read, T_SETUP=2, T_STROBE=3, T_HOLD=1, T_TURN=2: model drives P=0x3C while RDB low.
  -> RDB low exactly 3 cycles, P hi-Z from DATA_SETUP onward, rd_data=0x3C with rd_valid and rd_last, one done pulse.
- Read burst: addr=0xFE, len=3, inc=1.
  -> address phases 0xFE, 0xFF, 0x00, 0x01; four rd_valid pulses, rd_last only on the 4th; one done.
- Write burst: len=2, inc=0, wd_valid withheld 5 cycles before beat 1.
  -> bus stays idle with wd_ready=1 during the stall; all three address phases use the same address; data 0x11, 0x22, 0x33 in order.
- rst asserted in DATA_STROBE of a write.
  -> next cycle CSB=WRB=1 and P hi-Z; no done; cmd_ready=1 the cycle after rst drops; a new command executes normally.
- Back-to-back: cmd_valid held high with a second command.
  -> second command accepted in the done cycle; its ADDR_SETUP begins the next cycle; no overlap of CSB low between commands.
